// File: rtl/irq_ctrl_pkg.sv
// Shared constants, FSM states and helpers for the machine-level interrupt collector.
package irq_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    // mcause exception codes for the three machine interrupt sources
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

    // Bit positions inside mip / mie
    localparam int unsigned MIP_MSIP = 0;
    localparam int unsigned MIP_MTIP = 1;
    localparam int unsigned MIP_MEIP = 2;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'b00,
        IRQ_REQ  = 2'b01,
        IRQ_TRAP = 2'b10
    } irq_state_e;

    // Builds an interrupt mcause value: interrupt flag in the MSB, code in [3:0]
    function automatic logic [XLEN-1:0] irq_mcause(input logic [3:0] code);
        logic [XLEN-1:0] cause;
        cause            = '0;
        cause[XLEN-1]    = 1'b1;
        cause[3:0]       = code;
        return cause;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Interrupt source, CSR and trap-unit signals of the interrupt collector.
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic            i_tip;
    logic            i_sip;
    logic            i_eip_async;
    logic            i_gie;
    logic [2:0]      i_mie;
    logic            i_irq_ack;
    logic            i_mret;
    logic [2:0]      o_mip;
    logic            o_irq_req;
    logic [XLEN-1:0] o_irq_cause;

    // Trap unit / CSR side: drives sources and handshakes, observes the request
    modport master (
        output i_tip, i_sip, i_eip_async, i_gie, i_mie, i_irq_ack, i_mret,
        input  o_mip, o_irq_req, o_irq_cause
    );

    // Interrupt collector side
    modport slave (
        input  i_tip, i_sip, i_eip_async, i_gie, i_mie, i_irq_ack, i_mret,
        output o_mip, o_irq_req, o_irq_cause
    );

endinterface

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for the asynchronous external interrupt, with rising-edge detect
// taken at the last synchroniser stage.
module irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Shift the async input through the chain; remember the previous last-stage value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/irq_ctrl.sv
// Machine-level interrupt collector: registers pending bits, masks and prioritises them, and
// holds one registered trap request until the trap unit takes it; no new request until mret.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EXT_EDGE    = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    irq_ctrl_if.slave  bus
);

    logic            eip_level;
    logic            eip_rise;
    logic            edge_clr;

    logic [2:0]      mip_q, mip_d;
    logic [2:0]      eligible;
    irq_state_e      state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [1:0]      src_q, src_d;
    logic [1:0]      best_src;
    logic [3:0]      best_code;
    logic            withdraw;

    irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (bus.i_eip_async),
        .o_level (eip_level),
        .o_rise  (eip_rise)
    );

    // The edge-pending latch is cleared only by the ack that takes a latched MEI request
    assign edge_clr = (state_q == IRQ_REQ) && bus.i_irq_ack && (src_q == 2'(MIP_MEIP));

    // Next pending bits; in edge mode MEIP is itself the edge latch (a new edge beats a clear)
    always_comb begin
        mip_d           = '0;
        mip_d[MIP_MSIP] = bus.i_sip;
        mip_d[MIP_MTIP] = bus.i_tip;
        if (EXT_EDGE != 0) begin
            mip_d[MIP_MEIP] = eip_rise | (mip_q[MIP_MEIP] & ~edge_clr);
        end else begin
            mip_d[MIP_MEIP] = eip_level;
        end
    end

    assign eligible = mip_q & bus.i_mie & {3{bus.i_gie}};

    // Fixed priority select: MEI > MSI > MTI
    always_comb begin
        best_src  = 2'(MIP_MTIP);
        best_code = IRQ_CODE_MTI;
        if (eligible[MIP_MEIP]) begin
            best_src  = 2'(MIP_MEIP);
            best_code = IRQ_CODE_MEI;
        end else if (eligible[MIP_MSIP]) begin
            best_src  = 2'(MIP_MSIP);
            best_code = IRQ_CODE_MSI;
        end
    end

    // The latched source is no longer pending, enabled or globally allowed
    assign withdraw = ~mip_q[src_q] | ~bus.i_mie[src_q] | ~bus.i_gie;

    // Request FSM next state; cause and source are only updated when a request is issued
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cause_d = cause_q;
        src_d   = src_q;
        unique case (state_q)
            IRQ_IDLE: begin
                req_d = 1'b0;
                if (eligible != 3'b000) begin
                    state_d = IRQ_REQ;
                    req_d   = 1'b1;
                    cause_d = irq_mcause(best_code);
                    src_d   = best_src;
                end
            end
            IRQ_REQ: begin
                // Ack has precedence over a simultaneous withdraw
                if (bus.i_irq_ack) begin
                    state_d = IRQ_TRAP;
                    req_d   = 1'b0;
                end else if (withdraw) begin
                    state_d = IRQ_IDLE;
                    req_d   = 1'b0;
                end
            end
            IRQ_TRAP: begin
                req_d = 1'b0;
                if (bus.i_mret) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, pending and request registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IRQ_IDLE;
            mip_q   <= '0;
            req_q   <= 1'b0;
            cause_q <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            mip_q   <= mip_d;
            req_q   <= req_d;
            cause_q <= cause_d;
            src_q   <= src_d;
        end
    end

    assign bus.o_mip       = mip_q;
    assign bus.o_irq_req   = req_q;
    assign bus.o_irq_cause = cause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a level-mode instance and an edge-mode instance share clock/reset.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic bad;

    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    always #5 clk = ~clk;

    irq_ctrl_if lvl ();
    irq_ctrl_if edg ();

    irq_ctrl #(
        .SYNC_STAGES (2),
        .EXT_EDGE    (0)
    ) dut_lvl (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (lvl)
    );

    irq_ctrl #(
        .SYNC_STAGES (2),
        .EXT_EDGE    (1)
    ) dut_edg (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (edg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        lvl.i_tip = 0; lvl.i_sip = 0; lvl.i_eip_async = 0; lvl.i_gie = 0;
        lvl.i_mie = 3'b000; lvl.i_irq_ack = 0; lvl.i_mret = 0;
        edg.i_tip = 0; edg.i_sip = 0; edg.i_eip_async = 0; edg.i_gie = 0;
        edg.i_mie = 3'b000; edg.i_irq_ack = 0; edg.i_mret = 0;
        tick(2);
        chk("rst_req", 32'(lvl.o_irq_req), 0);
        chk("rst_mip", 32'(lvl.o_mip), 0);
        chk("rst_cause", lvl.o_irq_cause, 0);
        chk("rst_edg_mip", 32'(edg.o_mip), 0);
        rst = 1'b0;

        // Timer request, ack, then TRAP holds off the still-pending timer
        lvl.i_gie = 1; lvl.i_mie = 3'b010;
        tick(2);
        chk("t1_idle_req", 32'(lvl.o_irq_req), 0);
        lvl.i_tip = 1;
        tick(1);
        chk("t1_mip", 32'(lvl.o_mip), 32'b010);
        chk("t1_req_early", 32'(lvl.o_irq_req), 0);
        tick(1);
        chk("t1_req", 32'(lvl.o_irq_req), 1);
        chk("t1_cause", lvl.o_irq_cause, CAUSE_MTI);
        tick(1);
        chk("t1_req_hold", 32'(lvl.o_irq_req), 1);
        lvl.i_irq_ack = 1;
        tick(1);
        lvl.i_irq_ack = 0;
        chk("t1_ack_req", 32'(lvl.o_irq_req), 0);

        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (lvl.o_irq_req !== 1'b0) bad = 1'b1;
        end
        chk("t4_trap_hold", 32'(bad), 0);
        lvl.i_mret = 1;
        tick(1);
        lvl.i_mret = 0;
        chk("t4_mret_n1", 32'(lvl.o_irq_req), 0);
        tick(1);
        chk("t4_mret_n2", 32'(lvl.o_irq_req), 1);
        chk("t4_cause", lvl.o_irq_cause, CAUSE_MTI);

        // Withdraw by dropping the source, then ack coincident with the drop
        lvl.i_tip = 0;
        tick(1);
        chk("t3_mip_drop", 32'(lvl.o_mip), 0);
        chk("t3_req_still", 32'(lvl.o_irq_req), 1);
        tick(1);
        chk("t3_withdraw", 32'(lvl.o_irq_req), 0);
        tick(2);
        chk("t3_idle", 32'(lvl.o_irq_req), 0);
        lvl.i_tip = 1;
        tick(2);
        chk("t3_rereq", 32'(lvl.o_irq_req), 1);
        lvl.i_tip = 0; lvl.i_irq_ack = 1;
        tick(1);
        lvl.i_irq_ack = 0;
        chk("t3_ack_wins", 32'(lvl.o_irq_req), 0);
        lvl.i_tip = 1;
        tick(3);
        chk("t3_in_trap", 32'(lvl.o_irq_req), 0);
        lvl.i_mret = 1;
        tick(1);
        lvl.i_mret = 0;
        tick(1);
        chk("t3_after_mret", 32'(lvl.o_irq_req), 1);

        // Withdraw through gie and mie
        lvl.i_gie = 0;
        tick(1);
        chk("gie_withdraw", 32'(lvl.o_irq_req), 0);
        tick(3);
        chk("gie_masked", 32'(lvl.o_irq_req), 0);
        lvl.i_gie = 1;
        tick(1);
        chk("gie_restore", 32'(lvl.o_irq_req), 1);
        lvl.i_mie = 3'b000;
        tick(1);
        chk("mie_withdraw", 32'(lvl.o_irq_req), 0);
        lvl.i_mie = 3'b010;
        tick(1);
        chk("mie_restore", 32'(lvl.o_irq_req), 1);
        lvl.i_irq_ack = 1;
        tick(1);
        lvl.i_irq_ack = 0; lvl.i_tip = 0;
        tick(1);
        lvl.i_mret = 1;
        tick(1);
        lvl.i_mret = 0;
        tick(2);
        chk("quiet_idle", 32'(lvl.o_irq_req), 0);

        // Software and external together: MSI wins first, cause stays while MEIP arrives
        lvl.i_mie = 3'b111; lvl.i_sip = 1; lvl.i_eip_async = 1;
        tick(1);
        chk("t2_mip1", 32'(lvl.o_mip), 32'b001);
        tick(1);
        chk("t2_req", 32'(lvl.o_irq_req), 1);
        chk("t2_cause", lvl.o_irq_cause, CAUSE_MSI);
        tick(1);
        chk("t2_mip_meip", 32'(lvl.o_mip), 32'b101);
        chk("t2_cause_hold1", lvl.o_irq_cause, CAUSE_MSI);
        tick(1);
        chk("t2_cause_hold2", lvl.o_irq_cause, CAUSE_MSI);
        lvl.i_irq_ack = 1;
        tick(1);
        lvl.i_irq_ack = 0;
        chk("t2_ack", 32'(lvl.o_irq_req), 0);
        lvl.i_sip = 0; lvl.i_eip_async = 0;
        tick(4);
        chk("t2_mip_clear", 32'(lvl.o_mip), 0);
        lvl.i_mret = 1;
        tick(1);
        lvl.i_mret = 0;
        tick(2);
        chk("t2_idle", 32'(lvl.o_irq_req), 0);

        // MSI beats MTI when both rise together
        lvl.i_tip = 1; lvl.i_sip = 1;
        tick(2);
        chk("prio_cause", lvl.o_irq_cause, CAUSE_MSI);
        lvl.i_irq_ack = 1;
        tick(1);
        lvl.i_irq_ack = 0; lvl.i_sip = 0;
        tick(2);
        lvl.i_mret = 1;
        tick(1);
        lvl.i_mret = 0;
        tick(1);
        chk("t6_pre_req", 32'(lvl.o_irq_req), 1);
        chk("t6_pre_cause", lvl.o_irq_cause, CAUSE_MTI);

        // Reset while in REQ, request re-issued afterwards
        rst = 1;
        tick(1);
        rst = 0;
        chk("t6_rst_req", 32'(lvl.o_irq_req), 0);
        chk("t6_rst_mip", 32'(lvl.o_mip), 0);
        chk("t6_rst_cause", lvl.o_irq_cause, 0);
        tick(1);
        chk("t6_mip", 32'(lvl.o_mip), 32'b010);
        chk("t6_req_early", 32'(lvl.o_irq_req), 0);
        tick(1);
        chk("t6_req", 32'(lvl.o_irq_req), 1);
        chk("t6_cause", lvl.o_irq_cause, CAUSE_MTI);

        // Edge mode: a single pulse is latched and cleared by the ack
        edg.i_gie = 1; edg.i_mie = 3'b100;
        edg.i_eip_async = 1;
        tick(1);
        edg.i_eip_async = 0;
        chk("t5_mip_s1", 32'(edg.o_mip), 0);
        tick(1);
        chk("t5_mip_s2", 32'(edg.o_mip), 0);
        tick(1);
        chk("t5_meip", 32'(edg.o_mip), 32'b100);
        tick(1);
        chk("t5_req", 32'(edg.o_irq_req), 1);
        chk("t5_cause", edg.o_irq_cause, CAUSE_MEI);
        tick(3);
        chk("t5_meip_held", 32'(edg.o_mip), 32'b100);
        edg.i_irq_ack = 1;
        tick(1);
        edg.i_irq_ack = 0;
        chk("t5_ack_req", 32'(edg.o_irq_req), 0);
        chk("t5_ack_clr", 32'(edg.o_mip), 0);
        edg.i_mret = 1;
        tick(1);
        edg.i_mret = 0;
        tick(2);
        chk("t5_idle", 32'(edg.o_irq_req), 0);

        // Second edge lands in the same cycle as the clearing ack
        edg.i_eip_async = 1;
        tick(1);
        edg.i_eip_async = 0;
        tick(3);
        chk("t5b_req", 32'(edg.o_irq_req), 1);
        edg.i_eip_async = 1;
        tick(1);
        edg.i_eip_async = 0;
        tick(1);
        chk("t5b_req_pre_ack", 32'(edg.o_irq_req), 1);
        edg.i_irq_ack = 1;
        tick(1);
        edg.i_irq_ack = 0;
        chk("t5b_ack_req", 32'(edg.o_irq_req), 0);
        chk("t5b_set_wins", 32'(edg.o_mip), 32'b100);
        tick(2);
        chk("t5b_meip_held", 32'(edg.o_mip), 32'b100);
        edg.i_mret = 1;
        tick(1);
        edg.i_mret = 0;
        tick(1);
        chk("t5b_rereq", 32'(edg.o_irq_req), 1);
        chk("t5b_cause", edg.o_irq_cause, CAUSE_MEI);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
